// File: rtl/aes_io_stage.sv
// Word-stream wrapper around the AES core: packs key/data words, starts the core, streams the result out.
// Optional macro AES_IO_ZEROIZE_EN clears key, block and result after an unload or a watchdog abort.
module aes_io_stage #(
    parameter int DONE_TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic         in_enc_dec,
    output logic         core_start,
    output logic [1:0]   core_mode,
    output logic         core_enc_dec,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    input  logic         core_done,
    input  logic [127:0] core_result,
    output logic         out_valid,
    output logic [31:0]  out_data,
    input  logic         out_ready,
    output logic         error
);

    localparam int WD_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_DATA, START, WAIT, UNLOAD} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [WD_W-1:0]   wd;
    logic [127:0]      result;
    logic              illegal_err;
    logic              accept;
    logic              timeout;
    logic [2:0]        key_last;
    logic [1:0]        nxt_word;

    assign in_ready = (state == IDLE) || (state == LOAD_KEY) || (state == LOAD_DATA);
    assign accept   = in_valid & in_ready;
    assign nxt_word = cnt[1:0] + 2'd1;

    // Timeout is decoded from the live core_done so a same-cycle done always wins,
    // and the error lands in the DONE_TIMEOUT-th WAIT cycle rather than one later.
    assign timeout  = (state == WAIT) && !core_done && (wd == WD_W'(DONE_TIMEOUT - 1));
    assign error    = illegal_err | timeout;

    always_comb begin
        case (core_mode)
            2'b01:   key_last = 3'd5;
            2'b10:   key_last = 3'd7;
            default: key_last = 3'd3;
        endcase
    end

`ifdef AES_IO_ZEROIZE_EN
    logic clear_regs;
    assign clear_regs = timeout || ((state == UNLOAD) && out_ready && (cnt == 3'd3));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            wd           <= '0;
            result       <= '0;
            illegal_err  <= 1'b0;
            core_start   <= 1'b0;
            core_mode    <= '0;
            core_enc_dec <= 1'b0;
            core_key     <= '0;
            core_block   <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            core_start  <= 1'b0;
            illegal_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_mode == 2'b11) begin
                            illegal_err <= 1'b1;
                        end else begin
                            core_mode    <= in_mode;
                            core_enc_dec <= in_enc_dec;
                            core_key     <= {in_data, 224'b0};
                            cnt          <= 3'd1;
                            state        <= LOAD_KEY;
                        end
                    end
                end
                LOAD_KEY: begin
                    if (accept) begin
                        // ~cnt selects word cnt counted from the MSW end (32*(7-cnt)).
                        core_key[{~cnt, 5'd0} +: 32] <= in_data;
                        if (cnt == key_last) begin
                            cnt   <= '0;
                            state <= LOAD_DATA;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                LOAD_DATA: begin
                    if (accept) begin
                        core_block[{~cnt[1:0], 5'd0} +: 32] <= in_data;
                        if (cnt == 3'd3) begin
                            cnt        <= '0;
                            core_start <= 1'b1;
                            state      <= START;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                START: begin
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        result    <= core_result;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= core_result[127:96];
                        state     <= UNLOAD;
                    end else if (timeout) begin
                        state <= IDLE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (cnt == 3'd3) begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cnt      <= cnt + 3'd1;
                            out_data <= result[{~nxt_word, 5'd0} +: 32];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef AES_IO_ZEROIZE_EN
            if (clear_regs) begin
                core_key   <= '0;
                core_block <= '0;
                result     <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_io_stage.sv
// Bench for aes_io_stage: transaction-level model of packing, start timing, unload order and watchdog.
// Honours AES_IO_ZEROIZE_EN when checking register contents after a transaction.
module tb_aes_io_stage;

    localparam int TO = 31;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic         in_enc_dec;
    logic         core_start;
    logic [1:0]   core_mode;
    logic         core_enc_dec;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;
    logic         out_valid;
    logic [31:0]  out_data;
    logic         out_ready = 1'b1;
    logic         error;

    aes_io_stage #(.DONE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .in_mode(in_mode), .in_enc_dec(in_enc_dec),
        .core_start(core_start), .core_mode(core_mode), .core_enc_dec(core_enc_dec),
        .core_key(core_key), .core_block(core_block),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [255:0] exp_key;
    logic [127:0] exp_block;
    logic [1:0]   exp_mode;
    logic         exp_ed;
    logic [31:0]  exp_out[$];
    logic [31:0]  got_out[$];
    int start_pending = 0;
    int acc_cyc = 0, start_cyc = 0, done_cyc = 0, err_cyc = 0;
    int start_cnt = 0, hs_cnt = 0, err_cnt = 0, out_cnt = 0;
    logic hold_pend = 1'b0, ov_prev = 1'b0;
    logic [31:0] held = '0;
    int bp_en = 0, stall_req = 0, stall_left = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=no-event required=event-within-bound", nm);
    endtask

    // Compare process: checks every start, every output handshake, hold stability and latencies.
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
            ov_prev   = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                hs_cnt++;
                acc_cyc = cyc;
            end
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
                chki("start_latency", cyc, acc_cyc + 1);
                chki("start_expected", start_pending, 1);
                start_pending = 0;
                chk("start_key", core_key, exp_key);
                chk("start_block", 256'(core_block), 256'(exp_block));
                chk("start_mode", 256'(core_mode), 256'(exp_mode));
                chk("start_enc_dec", 256'(core_enc_dec), 256'(exp_ed));
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (hold_pend && out_valid)
                chk("out_hold", 256'(out_data), 256'(held));
            if (out_valid && !ov_prev)
                chki("out_latency", cyc, done_cyc + 1);
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out actual=%h required=no-word", out_data);
                end else begin
                    chk("out_word", 256'(out_data), 256'(exp_out.pop_front()));
                end
                got_out.push_back(out_data);
                out_cnt++;
            end
            hold_pend = out_valid && !out_ready;
            held      = out_data;
            ov_prev   = out_valid;
        end
    end

    // Downstream: optional random backpressure and a directed 3-cycle stall on result word 1.
    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (stall_req != 0 && out_valid && (out_cnt % 4) == 1) begin
            out_ready  = 1'b0;
            stall_req  = 0;
            stall_left = 2;
        end else begin
            out_ready = (bp_en != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [1:0] m, input logic ed, input int maxgap);
        int g;
        int n;
        g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        repeat (g) begin
            in_data = $urandom;
            @(posedge clk); #1;
        end
        in_valid = 1'b1; in_data = d; in_mode = m; in_enc_dec = ed;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                fail("accept_timeout");
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom; in_mode = 2'($urandom); in_enc_dec = 1'($urandom);
    endtask

    // Drives a full load; returns in the cycle where core_start must be high.
    task automatic load(input logic [1:0] m, input logic ed, input logic [31:0] w[12], input int maxgap);
        int nk;
        nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
        exp_key = '0;
        for (int i = 0; i < nk; i++) exp_key = (exp_key << 32) | 256'(w[i]);
        exp_key   = exp_key << (32 * (8 - nk));
        exp_block = {w[nk], w[nk+1], w[nk+2], w[nk+3]};
        exp_mode  = m;
        exp_ed    = ed;
        start_pending = 1;
        for (int i = 0; i < nk + 4; i++)
            send_word(w[i], (i == 0) ? m : 2'($urandom), (i == 0) ? ed : 1'($urandom), maxgap);
    endtask

    // Core model: done k cycles after the start cycle, with junk input offered while busy.
    task automatic respond(input logic [127:0] r, input int k);
        in_valid = 1'b1; in_data = $urandom; in_mode = 2'($urandom);
        repeat (k) begin
            @(posedge clk); #1;
            in_data = $urandom;
        end
        in_valid = 1'b0; core_done = 1'b1; core_result = r; done_cyc = cyc;
        for (int i = 0; i < 4; i++) exp_out.push_back(32'(r >> (96 - 32 * i)));
        @(posedge clk); #1;
        core_done = 1'b0; core_result = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_unload();
        int n;
        n = 0;
        while ((exp_out.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail("unload_timeout");
        @(posedge clk); #1;
    endtask

    task automatic finish_tx(input logic [127:0] r, input int k, input int e0, input int s0);
        respond(r, k);
        wait_unload();
        chki("tx_start_once", start_cnt, s0 + 1);
        chki("tx_no_error", err_cnt, e0);
        chki("tx_start_seen", start_pending, 0);
`ifdef AES_IO_ZEROIZE_EN
        chk("zeroize_key", core_key, '0);
        chk("zeroize_block", 256'(core_block), '0);
`else
        chk("key_retained", core_key, exp_key);
        chk("block_retained", 256'(core_block), 256'(exp_block));
`endif
    endtask

    initial begin
        logic [31:0]  w[12];
        logic [127:0] r;
        int e0, s0, n;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; in_enc_dec = 1'b0;
        core_done = 1'b0; core_result = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_core_start", 256'(core_start), '0);
        chk("rst_out_valid", 256'(out_valid), '0);
        chk("rst_error", 256'(error), '0);
        chk("rst_core_mode", 256'(core_mode), '0);
        chk("rst_enc_dec", 256'(core_enc_dec), '0);
        chk("rst_out_data", 256'(out_data), '0);
        chk("rst_core_key", core_key, '0);
        chk("rst_core_block", 256'(core_block), '0);
        @(posedge clk); #1;

        // AES-128 vector, no gaps, minimum core latency
        w = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
              32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734, 0, 0, 0, 0};
        e0 = err_cnt; s0 = start_cnt; hs_cnt = 0; got_out.delete();
        load(2'b00, 1'b1, w, 0);
        chk("aes128_key_lit", core_key, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        chk("aes128_block_lit", 256'(core_block), 256'(128'h3243f6a8885a308d313198a2e0370734));
        chk("aes128_start_now", 256'(core_start), 256'(1));
        chki("aes128_handshakes", hs_cnt, 8);
        finish_tx(128'h3925841d02dc09fbdc118597196a0b32, 1, e0, s0);
        chki("aes128_out_count", got_out.size(), 4);
        if (got_out.size() == 4) begin
            chk("aes128_out0", 256'(got_out[0]), 256'(32'h3925841d));
            chk("aes128_out1", 256'(got_out[1]), 256'(32'h02dc09fb));
            chk("aes128_out2", 256'(got_out[2]), 256'(32'hdc118597));
            chk("aes128_out3", 256'(got_out[3]), 256'(32'h196a0b32));
        end

        // AES-256 key load 0..7 with input gaps
        for (int i = 0; i < 12; i++) w[i] = 32'(i);
        e0 = err_cnt; s0 = start_cnt; hs_cnt = 0;
        load(2'b10, 1'b0, w, 3);
        chk("aes256_key_lit", core_key, {32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
        chki("aes256_handshakes", hs_cnt, 12);
        finish_tx({$urandom, $urandom, $urandom, $urandom}, 3, e0, s0);

        // Illegal mode, then a 192-bit load
        e0 = err_cnt; hs_cnt = 0;
        send_word(32'hdeadbeef, 2'b11, 1'b1, 0);
        @(negedge clk);
        chk("illegal_error", 256'(error), 256'(1));
        chk("illegal_idle", 256'(in_ready), 256'(1));
        @(negedge clk);
        chk("illegal_error_1cyc", 256'(error), '0);
        chki("illegal_err_count", err_cnt, e0 + 1);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        e0 = err_cnt; s0 = start_cnt; hs_cnt = 0;
        load(2'b01, 1'b1, w, 1);
        chki("aes192_handshakes", hs_cnt, 10);
        finish_tx({$urandom, $urandom, $urandom, $urandom}, 5, e0, s0);

        // Backpressure: out_ready low 3 cycles during word 1
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        e0 = err_cnt; s0 = start_cnt; got_out.delete();
        load(2'b00, 1'b0, w, 0);
        stall_req = 1;
        finish_tx(128'h00112233_44556677_8899aabb_ccddeeff, 2, e0, s0);
        chki("bp_out_count", got_out.size(), 4);
        if (got_out.size() == 4) begin
            chk("bp_out1", 256'(got_out[1]), 256'(32'h44556677));
            chk("bp_out2", 256'(got_out[2]), 256'(32'h8899aabb));
        end

        // Stray core_done while idle must be ignored
        core_done = 1'b1; core_result = {4{32'hcafef00d}};
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_done_no_out", 256'(out_valid), '0);
        chk("stray_done_idle", 256'(in_ready), 256'(1));
        @(posedge clk); #1;

        // Watchdog abort
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        e0 = err_cnt;
        load(2'b10, 1'b1, w, 0);
        n = 0;
        while (err_cnt == e0 && n < TO + 10) begin
            @(negedge clk);
            n++;
        end
        if (err_cnt == e0) fail("timeout_error");
        else chki("timeout_cycle", err_cyc, start_cyc + TO);
        @(negedge clk);
        chk("timeout_err_1cyc", 256'(error), '0);
        chk("timeout_idle", 256'(in_ready), 256'(1));
        chk("timeout_no_out", 256'(out_valid), '0);
`ifdef AES_IO_ZEROIZE_EN
        chk("timeout_zeroize", core_key, '0);
`else
        chk("timeout_key_kept", core_key, exp_key);
`endif
        @(posedge clk); #1;

        // core_done coinciding with watchdog expiry: done wins
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        e0 = err_cnt; s0 = start_cnt;
        load(2'b00, 1'b0, w, 0);
        finish_tx({$urandom, $urandom, $urandom, $urandom}, TO, e0, s0);

        // Reset after 2 data words, then a fresh transaction
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        send_word(w[0], 2'b00, 1'b1, 0);
        for (int i = 1; i < 6; i++) send_word(w[i], 2'($urandom), 1'b0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 256'(in_ready), 256'(1));
        chk("midrst_key", core_key, '0);
        chk("midrst_block", 256'(core_block), '0);
        chk("midrst_mode", 256'(core_mode), '0);
        chk("midrst_enc_dec", 256'(core_enc_dec), '0);
        chk("midrst_start", 256'(core_start), '0);
        chk("midrst_out", 256'({out_valid, error, out_data}), '0);
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) w[i] = $urandom;
        e0 = err_cnt; s0 = start_cnt;
        load(2'b00, 1'b1, w, 2);
        finish_tx({$urandom, $urandom, $urandom, $urandom}, 4, e0, s0);

        // Randomized transactions with gaps and backpressure
        bp_en = 1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 12; i++) w[i] = $urandom;
            e0 = err_cnt; s0 = start_cnt;
            load(2'($urandom_range(0, 2)), 1'($urandom), w, 2);
            r = {$urandom, $urandom, $urandom, $urandom};
            finish_tx(r, int'($urandom_range(1, 25)), e0, s0);
        end
        bp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
